if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset (bits [1:0] SHALL be zero).
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  in  1  hazard stall from decode; hold PC and IF/ID contents.
REQ-005 SHALL have port flush  in  1  squash the IF/ID contents (valid=0) on the next edge.
REQ-006 SHALL have port branch_taken  in  1  with branch_target  in  32, a redirect request.
REQ-007 SHALL have port jump  in  1  with jump_target  in  32, a redirect request that outranks branch.
REQ-008 SHALL have port imem_req  out  1, imem_addr  out  32, imem_rdata  in  32, imem_ready  in  1, the instruction memory handshake.
REQ-009 SHALL have port pc  out  32  current fetch PC, and pc_plus4  out  32  pc+4.
REQ-010 SHALL have port if_id_instr  out  32, if_id_pc4  out  32, if_id_valid  out  1, the IF/ID pipeline register.

Function
REQ-011 SHALL implement FSM states BOOT, FETCH, WAIT; BOOT->FETCH unconditionally after one cycle.
REQ-012 SHALL drive imem_req=0 in BOOT, 1 in FETCH and WAIT; imem_addr SHALL equal pc at all times.
REQ-013 SHALL compute pc_plus4 = pc + 32'd4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), combinationally.
REQ-014 SHALL force bits [1:0] of any redirect target to 00.
REQ-015 SHALL select next PC with priority jump > branch_taken > stall (hold) > pc_plus4.
REQ-016 FETCH with imem_ready=1: with a redirect, PC=target, IF/ID valid=0, instr=0; with stall and no redirect, PC and IF/ID hold; otherwise PC=pc_plus4 and IF/ID captures {imem_rdata, pc_plus4, valid=1}; state stays FETCH.
REQ-017 FETCH with imem_ready=0 SHALL go to WAIT with PC and IF/ID valid unchanged.
REQ-018 WAIT SHALL hold pc/imem_addr stable until imem_ready=1.
REQ-019 A redirect arriving in WAIT SHALL be latched into a pending register (jump wins when simultaneous; a later redirect overwrites an earlier one) and not applied to pc until imem_ready.
REQ-020 WAIT with imem_ready=1: if pending, imem_rdata SHALL be discarded, PC=pending target, IF/ID valid=0, pending cleared; else as REQ-016; then state=FETCH.
REQ-021 flush SHALL force if_id_valid=0 and if_id_instr=0 on the next edge, overriding stall and capture; PC behaviour is unaffected by flush.
REQ-022 Fetch latency SHALL be one cycle from imem_ready=1 to if_id_valid=1 (zero-wait memory: one instruction per cycle).

Reset
REQ-023 While rst_n=0: state=BOOT, pc=RESET_PC, pending cleared, if_id_instr=0, if_id_pc4=0, if_id_valid=0, imem_req=0, asynchronously.
REQ-024 Reset asserted in WAIT SHALL abandon the outstanding fetch; no IF/ID update from it.

Structure
REQ-025 SHALL place RESET_PC default, NOP encoding 32'h0000_0000, PC increment 4 and the FSM state encoding in a shared package mips_pkg.
REQ-026 SHALL implement IF/ID as one sub-module, if_id_reg (capture, hold, flush controls, async active-low reset).

Verification
REQ-027 Reset release, imem_ready=1 constant -> imem_addr 0,4,8,C on successive FETCH cycles; if_id_pc4 4,8,C one cycle later.
REQ-028 stall=1 for 2 cycles at pc=8 -> pc holds 8, if_id_instr/if_id_pc4 hold the pc=4 fetch (pc4=8); resumes at 8 after stall.
REQ-029 jump=1 (jump_target 0x100) and branch_taken=1 (branch_target 0x200) in same cycle at pc=0xC -> pc=0x100, if_id_valid=0 next cycle.
REQ-030 imem_ready=0 for 3 cycles at pc=0x10, branch to 0x40 in 2nd cycle -> addr stays 0x10; after ready, data dropped, pc=0x40, valid=0.
REQ-031 RESET_PC=32'hFFFF_FFF8, ready=1 -> pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-032 rst_n pulled low mid-WAIT -> pc=RESET_PC, if_id_valid=0, imem_req=0 immediately; no capture on later imem_ready.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// Holds the reset PC default, the NOP encoding, the PC increment and the fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } fetch_state_e;

  // Instruction addresses are word aligned, so redirect targets drop their low bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction with its pc+4.
// Squash beats capture, and capture beats hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        squash,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc4_d, pc4_q;
  logic        valid_d, valid_q;

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (squash) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (capture) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, redirect handling and the IF/ID register.
// Redirects that arrive while the memory is busy are parked until the fetch completes.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         pend_valid_d, pend_valid_q;
  logic [31:0]  pend_tgt_d, pend_tgt_q;

  logic         redir_now;
  logic [31:0]  redir_now_tgt;
  logic         redir_any;
  logic [31:0]  redir_tgt;
  logic         capture;
  logic         squash;

  assign pc_plus4  = pc_q + PC_INC;
  assign pc        = pc_q;
  assign imem_addr = pc_q;

  // A fresh redirect is newer than a parked one, so it wins when both exist.
  assign redir_now     = jump | branch_taken;
  assign redir_now_tgt = word_align(jump ? jump_target : branch_target);
  assign redir_any     = redir_now | pend_valid_q;
  assign redir_tgt     = redir_now ? redir_now_tgt : pend_tgt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_tgt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (!imem_ready) state_d = S_WAIT;
      S_WAIT:  if (imem_ready) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    imem_req     = (state_q != S_BOOT);
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;
    capture      = 1'b0;
    squash       = flush;
    if (state_q != S_BOOT) begin
      if (imem_ready) begin
        pend_valid_d = 1'b0;
        if (redir_any) begin
          pc_d   = redir_tgt;
          squash = 1'b1;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          capture = 1'b1;
        end
      end else if (redir_now) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = redir_now_tgt;
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .squash   (squash),
    .instr_in (imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a vector table for single-cycle behaviour plus
// hand-written reset sequences; a second instance covers the wrapping reset PC.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target, imem_rdata;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, pc, pc_plus4, if_id_instr, if_id_pc4;

  logic        imem_req2, if_id_valid2;
  logic [31:0] imem_addr2, pc2, pc_plus4_2, if_id_instr2, if_id_pc4_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .pc(pc2), .pc_plus4(pc_plus4_2),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc4_2), .if_id_valid(if_id_valid2)
  );

  typedef struct {
    logic        stall, flush, br, jmp, rdy, chk2;
    logic [31:0] bt, jt, rdata;
    logic [31:0] e_pc, e_instr, e_pc4, e_pc2;
    logic        e_valid;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                              input logic jm, input logic [31:0] jt, input logic rdy,
                              input logic [31:0] rdata, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_pc4,
                              input logic e_valid);
    vec_t v;
    v.stall = st; v.flush = fl; v.br = br; v.bt = bt; v.jmp = jm; v.jt = jt;
    v.rdy = rdy; v.rdata = rdata; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_pc4 = e_pc4; v.e_valid = e_valid; v.chk2 = 1'b0; v.e_pc2 = '0;
    return v;
  endfunction

  task automatic drive_idle();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0; imem_ready = 1; imem_rdata = '0;
  endtask

  task automatic check_if_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic e_req);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " imem_addr"}, imem_addr, e_pc);
    check({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    check({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, e_req});
    check({tag, " if_id_valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    check({tag, " if_id_instr"}, if_id_instr, e_instr);
    check({tag, " if_id_pc4"}, if_id_pc4, e_pc4);
  endtask

  localparam logic [31:0] I0  = 32'h1111_0000, I1  = 32'h1111_0004, I2  = 32'h1111_0008;
  localparam logic [31:0] I3  = 32'h1111_000C, I4  = 32'h2222_0100, I5  = 32'h2222_0200;
  localparam logic [31:0] I6  = 32'h2222_0204, I7  = 32'h2222_0208, I8  = 32'h3333_000C;
  localparam logic [31:0] I9  = 32'hDEAD_BEEF, I10 = 32'h3333_0040, I11 = 32'h3333_0044;
  localparam logic [31:0] I12 = 32'h4444_0500, I13 = 32'h5555_0000;

  initial begin
    //             st fl br bt           jm jt           rdy rdata  e_pc         e_instr e_pc4        v
    vecs[0]  = mk(0, 0, 0, 0,           0, 0,           1, I0,  32'h0000_0004, I0,  32'h0000_0004, 1);
    vecs[1]  = mk(0, 0, 0, 0,           0, 0,           1, I1,  32'h0000_0008, I1,  32'h0000_0008, 1);
    vecs[2]  = mk(1, 0, 0, 0,           0, 0,           1, I2,  32'h0000_0008, I1,  32'h0000_0008, 1);
    vecs[3]  = mk(1, 0, 0, 0,           0, 0,           1, I2,  32'h0000_0008, I1,  32'h0000_0008, 1);
    vecs[4]  = mk(0, 0, 0, 0,           0, 0,           1, I2,  32'h0000_000C, I2,  32'h0000_000C, 1);
    vecs[5]  = mk(0, 0, 1, 32'h200,     1, 32'h100,     1, I3,  32'h0000_0100, 0,   32'h0000_000C, 0);
    vecs[6]  = mk(0, 0, 0, 0,           0, 0,           1, I4,  32'h0000_0104, I4,  32'h0000_0104, 1);
    vecs[7]  = mk(0, 0, 1, 32'h203,     0, 0,           1, I9,  32'h0000_0200, 0,   32'h0000_0104, 0);
    vecs[8]  = mk(0, 0, 0, 0,           0, 0,           1, I5,  32'h0000_0204, I5,  32'h0000_0204, 1);
    vecs[9]  = mk(1, 1, 0, 0,           0, 0,           1, I6,  32'h0000_0204, 0,   32'h0000_0204, 0);
    vecs[10] = mk(0, 1, 0, 0,           0, 0,           1, I6,  32'h0000_0208, 0,   32'h0000_0204, 0);
    vecs[11] = mk(0, 0, 0, 0,           0, 0,           1, I7,  32'h0000_020C, I7,  32'h0000_020C, 1);
    vecs[12] = mk(0, 0, 0, 0,           1, 32'h00E,     1, I9,  32'h0000_000C, 0,   32'h0000_020C, 0);
    vecs[13] = mk(0, 0, 0, 0,           0, 0,           1, I8,  32'h0000_0010, I8,  32'h0000_0010, 1);
    vecs[14] = mk(0, 0, 0, 0,           0, 0,           0, I9,  32'h0000_0010, I8,  32'h0000_0010, 1);
    vecs[15] = mk(0, 0, 1, 32'h040,     0, 0,           0, I9,  32'h0000_0010, I8,  32'h0000_0010, 1);
    vecs[16] = mk(0, 0, 0, 0,           0, 0,           0, I9,  32'h0000_0010, I8,  32'h0000_0010, 1);
    vecs[17] = mk(0, 0, 0, 0,           0, 0,           1, I9,  32'h0000_0040, 0,   32'h0000_0010, 0);
    vecs[18] = mk(0, 0, 0, 0,           0, 0,           1, I10, 32'h0000_0044, I10, 32'h0000_0044, 1);
    vecs[19] = mk(0, 0, 0, 0,           0, 0,           0, I9,  32'h0000_0044, I10, 32'h0000_0044, 1);
    vecs[20] = mk(0, 0, 0, 0,           0, 0,           1, I11, 32'h0000_0048, I11, 32'h0000_0048, 1);
    vecs[21] = mk(0, 0, 0, 0,           0, 0,           0, I9,  32'h0000_0048, I11, 32'h0000_0048, 1);
    vecs[22] = mk(0, 0, 0, 0,           1, 32'h300,     0, I9,  32'h0000_0048, I11, 32'h0000_0048, 1);
    vecs[23] = mk(0, 0, 1, 32'h400,     0, 0,           0, I9,  32'h0000_0048, I11, 32'h0000_0048, 1);
    vecs[24] = mk(0, 0, 0, 0,           0, 0,           1, I9,  32'h0000_0400, 0,   32'h0000_0048, 0);
    vecs[25] = mk(0, 0, 0, 0,           0, 0,           0, I9,  32'h0000_0400, 0,   32'h0000_0048, 0);
    vecs[26] = mk(0, 0, 1, 32'h600,     1, 32'h500,     0, I9,  32'h0000_0400, 0,   32'h0000_0048, 0);
    vecs[27] = mk(0, 0, 0, 0,           0, 0,           1, I9,  32'h0000_0500, 0,   32'h0000_0048, 0);
    vecs[28] = mk(0, 0, 0, 0,           0, 0,           1, I12, 32'h0000_0504, I12, 32'h0000_0504, 1);
    // Wrapping reset PC on the second instance: F8 -> FC -> 0.
    vecs[0].chk2 = 1'b1; vecs[0].e_pc2 = 32'hFFFF_FFFC;
    vecs[1].chk2 = 1'b1; vecs[1].e_pc2 = 32'h0000_0000;

    rst_n = 1'b0;
    drive_idle();
    #12;
    check_if_id("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset dut2 pc", pc2, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    #2;
    check("boot imem_req", {31'b0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check_if_id("boot->fetch", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("boot dut2 pc", pc2, 32'hFFFF_FFF8);

    for (int i = 0; i < NVEC; i++) begin
      stall = vecs[i].stall; flush = vecs[i].flush;
      branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump = vecs[i].jmp; jump_target = vecs[i].jt;
      imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rdata;
      @(posedge clk); #1;
      check_if_id($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
                  vecs[i].e_valid, 1'b1);
      if (vecs[i].chk2) begin
        check($sformatf("vec%0d dut2 pc", i), pc2, vecs[i].e_pc2);
        check($sformatf("vec%0d dut2 pc_plus4", i), pc_plus4_2, vecs[i].e_pc2 + 32'd4);
      end
    end

    // Reset dropped while a fetch is outstanding abandons it.
    drive_idle();
    imem_ready = 1'b0;
    imem_rdata = I9;
    @(posedge clk); #1;
    check_if_id("enter wait", 32'h504, I12, 32'h504, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_if_id("async reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check_if_id("held reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_if_id("post reset boot", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    imem_rdata = I13;
    @(posedge clk); #1;
    check_if_id("post reset fetch", 32'h4, I13, 32'h4, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
